// File: rtl/batcharger_pkg.sv
// batcharger_pkg: shared state encoding and default threshold codes for the charge sequencer.
package batcharger_pkg;
    localparam int ADC_W = 8;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TC   = 3'd1,
        ST_CC   = 3'd2,
        ST_CV   = 3'd3,
        ST_DONE = 3'd4
    } state_t;
    localparam logic [ADC_W-1:0] VCUTOFF_DEF = 8'd153;
    localparam logic [ADC_W-1:0] VTARGET_DEF = 8'd188;
    localparam logic [ADC_W-1:0] VPRESET_DEF = 8'd184;
    localparam logic [ADC_W-1:0] IEND_DEF    = 8'd13;
endpackage

// File: rtl/batcharger_debounce.sv
// batcharger_debounce: saturating count of consecutive qualifying samples; hit flags the N-th one.
module batcharger_debounce #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic smp,
    input  logic ok,
    output logic hit
);
    localparam logic [3:0] NV  = 4'(N);
    localparam logic [3:0] NM1 = 4'(N - 1);
    logic [3:0] cnt;
    // hit is combinational so the owning FSM can move on the edge ending the N-th sample
    assign hit = smp & ok & (cnt >= NM1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (smp)
            cnt <= !ok ? 4'd0 : (cnt == NV) ? cnt : cnt + 4'd1;
    end
endmodule

// File: rtl/batcharger_controller.sv
// batcharger_controller: trickle -> CC -> CV -> done charge sequencer driving the power-block mode enables.
module batcharger_controller
    import batcharger_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TMR_W    = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             vtok,
    input  logic [ADC_W-1:0] vbat,
    input  logic [ADC_W-1:0] ibat,
    input  logic [ADC_W-1:0] vcutoff,
    input  logic [ADC_W-1:0] vtarget,
    input  logic [ADC_W-1:0] vpreset,
    input  logic [ADC_W-1:0] iend,
    input  logic [TMR_W-1:0] tmax,
    output logic             pwr_en,
    output logic             tc,
    output logic             cc,
    output logic             cv,
    output logic             done,
    output logic [2:0]       state
);
    state_t st, nxt;
    logic [TMR_W-1:0] tmr;
    logic ok, hit, clr, tmo;

    assign state = st;
    assign tmo   = (st == ST_CV) && (tmax != '0) && (tmr == tmax);
    assign clr   = ~en | (nxt != st);
    // one shared debouncer; what counts as a qualifying sample depends on the state
    assign ok = (st == ST_TC)   ? (vbat >= vcutoff) :
                (st == ST_CC)   ? (vbat >= vtarget) :
                (st == ST_DONE) ? (vbat <  vpreset) : 1'b0;

    batcharger_debounce #(.N(DEBOUNCE)) u_deb (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .smp (vtok),
        .ok  (ok),
        .hit (hit)
    );

    always_comb begin
        nxt = st;
        if (!en)
            nxt = ST_IDLE;
        else
            case (st)
                ST_IDLE: if (vtok) nxt = (vbat < vcutoff) ? ST_TC : (vbat < vtarget) ? ST_CC : ST_CV;
                ST_TC:   if (hit) nxt = ST_CC;
                ST_CC:   if (hit) nxt = ST_CV;
                ST_CV:   if ((vtok && (ibat < iend)) || tmo) nxt = ST_DONE;
                ST_DONE: if (hit) nxt = ST_CC;
                default: nxt = ST_IDLE;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= ST_IDLE;
            tmr    <= '0;
            pwr_en <= 1'b0;
            tc     <= 1'b0;
            cc     <= 1'b0;
            cv     <= 1'b0;
            done   <= 1'b0;
        end else begin
            st     <= nxt;
            tmr    <= (st != ST_CV) ? '0 : (&tmr) ? tmr : tmr + 1'b1;
            pwr_en <= (nxt == ST_TC) || (nxt == ST_CC) || (nxt == ST_CV);
            tc     <= nxt == ST_TC;
            cc     <= nxt == ST_CC;
            cv     <= nxt == ST_CV;
            done   <= nxt == ST_DONE;
        end
    end
endmodule
